// File: rtl/sd_cmd_phy_if.sv
// Command-master <-> command-PHY handshake bundle: command/settings in,
// response token and status out, plus the two four-phase req/ack pairs.
interface sd_cmd_phy_if;
  logic [39:0] cmd_in;
  logic [15:0] settings_i;
  logic        req_in;
  logic        ack_in;
  logic        go_idle_i;
  logic [39:0] cmd_out;
  logic        req_out;
  logic        ack_out;
  logic [7:0]  status_o;

  modport master (
    output cmd_in, settings_i, req_in, ack_in, go_idle_i,
    input  cmd_out, req_out, ack_out, status_o
  );

  modport slave (
    input  cmd_in, settings_i, req_in, ack_in, go_idle_i,
    output cmd_out, req_out, ack_out, status_o
  );
endinterface

// File: rtl/sd_cmd_phy.sv
// Bit-serial SD CMD-line engine: sends a 48-bit command frame with CRC7 and
// optionally collects a 48/136-bit response, reporting it via req/ack.
module sd_cmd_phy #(
  parameter int RESP_TIMEOUT = 64,
  parameter int SYNC_STAGES  = 2
) (
  input  logic         CLK_PAD_IO,
  input  logic         RST_PAD_I,
  sd_cmd_phy_if.slave  bus,
  input  logic         cmd_dat_i,
  output logic         cmd_out_o,
  output logic         cmd_oe_o
);

  localparam int TW = $clog2(RESP_TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, TX, WAIT_RSP, RX, GAP, REPORT, ACKWAIT} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] req_pipe, ack_pipe;
  logic                   req_s, ack_s;
  logic [15:0]            set_q;
  logic [39:0]            tx_sr, rx_sr;
  logic [6:0]             crc, rx_crc;
  logic [7:0]             bit_cnt;
  logic [TW-1:0]          tcnt;
  logic                   lng, crc_ok;
  logic [7:0]             crc_lo, crc_hi, rx_end;
  logic                   unused_set;

  function automatic logic [6:0] crc_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:0], fb} ^ {3'b000, fb, 3'b000};
  endfunction

  assign req_s      = req_pipe[SYNC_STAGES-1];
  assign ack_s      = ack_pipe[SYNC_STAGES-1];
  assign unused_set = ^set_q[15:11];

  // Long (R2) responses skip the 8 header bits in the CRC and keep the
  // last 40 bits before the end bit; short ones keep the first 40.
  assign lng    = (set_q[6:0] == 7'd127);
  assign crc_lo = lng ? 8'd8   : 8'd0;
  assign crc_hi = lng ? 8'd128 : 8'd40;
  assign rx_end = crc_hi + 8'd7;
  assign crc_ok = !set_q[7] || ((crc == rx_crc) && (lng || cmd_dat_i));

  always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
    if (RST_PAD_I) begin
      req_pipe <= '0;
      ack_pipe <= '0;
    end else begin
      req_pipe <= {req_pipe[SYNC_STAGES-2:0], bus.req_in};
      ack_pipe <= {ack_pipe[SYNC_STAGES-2:0], bus.ack_in};
    end
  end

  always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
    if (RST_PAD_I) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (req_s) state_nxt = TX;
      TX:       if (bit_cnt == 8'd48) state_nxt = (set_q[6:0] == 7'd0) ? GAP : WAIT_RSP;
      WAIT_RSP: if (!cmd_dat_i) state_nxt = RX;
                else if (tcnt == TW'(RESP_TIMEOUT)) state_nxt = GAP;
      RX:       if (bit_cnt == rx_end) state_nxt = GAP;
      GAP:      if (bit_cnt == {5'd0, set_q[10:8]}) state_nxt = REPORT;
      REPORT:   if (ack_s) state_nxt = ACKWAIT;
      ACKWAIT:  if (!ack_s) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (bus.go_idle_i) state_nxt = IDLE;
  end

  always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
    if (RST_PAD_I) begin
      cmd_oe_o     <= 1'b0;
      cmd_out_o    <= 1'b1;
      bus.req_out  <= 1'b0;
      bus.ack_out  <= 1'b0;
      bus.status_o <= 8'h00;
      bus.cmd_out  <= 40'd0;
      set_q        <= 16'd0;
      tx_sr        <= 40'd0;
      rx_sr        <= 40'd0;
      crc          <= 7'd0;
      rx_crc       <= 7'd0;
      bit_cnt      <= 8'd0;
      tcnt         <= '0;
    end else begin
      bus.ack_out <= (state_nxt == IDLE);
      if (bus.go_idle_i) begin
        cmd_oe_o     <= 1'b0;
        cmd_out_o    <= 1'b1;
        bus.req_out  <= 1'b0;
        bus.status_o <= 8'h00;
        bit_cnt      <= 8'd0;
        tcnt         <= '0;
      end else begin
        unique case (state)
          IDLE: if (req_s) begin
            set_q        <= bus.settings_i;
            tx_sr        <= {bus.cmd_in[38:0], 1'b0};
            crc          <= crc_step(7'd0, bus.cmd_in[39]);
            cmd_oe_o     <= 1'b1;
            cmd_out_o    <= bus.cmd_in[39];
            bit_cnt      <= 8'd1;
            bus.status_o <= 8'h01;
          end
          TX: begin
            if (bit_cnt == 8'd48) begin
              cmd_oe_o  <= 1'b0;
              cmd_out_o <= 1'b1;
              bit_cnt   <= 8'd0;
              tcnt      <= '0;
              if (set_q[6:0] == 7'd0) bus.status_o <= 8'h61;
            end else begin
              bit_cnt <= bit_cnt + 8'd1;
              if (bit_cnt < 8'd40) begin
                cmd_out_o <= tx_sr[39];
                tx_sr     <= {tx_sr[38:0], 1'b0};
                crc       <= crc_step(crc, tx_sr[39]);
              end else if (bit_cnt < 8'd47) begin
                cmd_out_o <= crc[6];
                crc       <= {crc[5:0], 1'b0};
              end else begin
                cmd_out_o <= 1'b1;
              end
            end
          end
          WAIT_RSP: begin
            // A start bit on the timeout cycle still wins.
            if (!cmd_dat_i) begin
              rx_sr   <= {rx_sr[38:0], 1'b0};
              crc     <= 7'd0;
              rx_crc  <= 7'd0;
              bit_cnt <= 8'd1;
            end else if (tcnt == TW'(RESP_TIMEOUT)) begin
              bus.status_o <= 8'h03;
              bit_cnt      <= 8'd0;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
          RX: begin
            if (bit_cnt < (lng ? rx_end : crc_hi)) rx_sr <= {rx_sr[38:0], cmd_dat_i};
            if (bit_cnt >= crc_lo && bit_cnt < crc_hi) crc <= crc_step(crc, cmd_dat_i);
            if (bit_cnt >= crc_hi && bit_cnt < rx_end) rx_crc <= {rx_crc[5:0], cmd_dat_i};
            if (bit_cnt == rx_end) begin
              bus.cmd_out  <= rx_sr;
              bus.status_o <= {1'b0, 1'b1, crc_ok, 4'b0000, 1'b1};
              bit_cnt      <= 8'd0;
            end else begin
              bit_cnt <= bit_cnt + 8'd1;
            end
          end
          GAP: begin
            if (bit_cnt == {5'd0, set_q[10:8]}) begin
              bit_cnt     <= 8'd0;
              bus.req_out <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 8'd1;
            end
          end
          REPORT:  if (ack_s) bus.req_out <= 1'b0;
          ACKWAIT: if (!ack_s) bus.status_o[0] <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule
